// File: rtl/rename_pkg.sv
// Shared rename types: scheduler FSM encoding and table timing constants.
// Pure declarations; no logic, no latency, no flow control.
package rename_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } rts_state_e;

    localparam int RTS_SETTLE_CYCLES  = 2;
    localparam int RTS_TBL_RD_LATENCY = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr_i, modulo NUM_WR.
// Combinational, zero latency; en_i low forces no grant.
module rr_arbiter #(
    parameter int NUM_WR = 2,
    parameter int IW     = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
    input  logic [NUM_WR-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    input  logic              en_i,
    output logic [NUM_WR-1:0] gnt_o,
    output logic [IW-1:0]     idx_o
);

    always_comb begin
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        if (en_i) begin
            for (int i = 1; i <= NUM_WR; i++) begin
                j = (int'(ptr_i) + i) % NUM_WR;
                if (!found && req_i[j]) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/rename_table_scheduler.sv
// Shares the rename table's write port (round-robin) and read port, tracks occupancy, runs flush drain.
// Grants are combinational; table enables 1 cycle after grant, rd_valid 2 cycles after rd_gnt.
module rename_table_scheduler
    import rename_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TABLE_DEPTH = 4,
    parameter int NUM_WR      = 2,
    parameter int CW          = $clog2(TABLE_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_WR-1:0]            wr_req,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]            wr_gnt,
    input  logic                         rd_req,
    output logic                         rd_gnt,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         flush,
    output logic                         flush_busy,
    output logic                         flush_done,
    output logic [CW-1:0]                occupancy,
    output logic                         tbl_write_enable,
    output logic                         tbl_read_enable,
    output logic [DATA_WIDTH-1:0]        tbl_data_in,
    input  logic [DATA_WIDTH-1:0]        tbl_data_out
);

    localparam int IW      = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int RD_PIPE = RTS_TBL_RD_LATENCY + 1;

    rts_state_e            state_q, state_d;
    logic [1:0]            settle_q, settle_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic [IW-1:0]         rr_ptr_q;
    logic [RD_PIPE-1:0]    rd_pipe_q;
    logic                  tbl_we_q, tbl_re_q;
    logic [DATA_WIDTH-1:0] tbl_din_q;

    logic                  grant_ok;
    logic                  wr_any, rd_any, drain_rd;
    logic [NUM_WR-1:0]     arb_gnt;
    logic [IW-1:0]         arb_idx;

    // Flush request in IDLE pre-empts every grant in that same cycle.
    assign grant_ok = (state_q == IDLE) && !flush;
    assign drain_rd = (state_q == DRAIN) && (occ_q != '0);

    rr_arbiter #(.NUM_WR(NUM_WR), .IW(IW)) u_arb (
        .req_i (wr_req),
        .ptr_i (rr_ptr_q),
        .en_i  (grant_ok && (occ_q < CW'(TABLE_DEPTH))),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign wr_gnt = arb_gnt;
    assign rd_gnt = grant_ok && rd_req && (occ_q != '0);
    assign wr_any = |arb_gnt;
    assign rd_any = rd_gnt || drain_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            IDLE:   if (flush) state_d = DRAIN;
            DRAIN: begin
                // Leave once the last record is being read this cycle (or none remain).
                if (occ_q <= CW'(1)) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (settle_q == 2'(RTS_SETTLE_CYCLES - 1)) state_d = DONE;
                else                                       settle_d = settle_q + 2'd1;
            end
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush_busy = (state_q != IDLE);
        flush_done = (state_q == DONE);
    end

    always_comb begin
        occ_d = occ_q;
        case ({wr_any, rd_any})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q     <= '0;
            rr_ptr_q  <= IW'(NUM_WR - 1);
            rd_pipe_q <= '0;
            tbl_we_q  <= 1'b0;
            tbl_re_q  <= 1'b0;
            tbl_din_q <= '0;
        end else begin
            occ_q     <= occ_d;
            rd_pipe_q <= {rd_pipe_q[RD_PIPE-2:0], rd_gnt};
            tbl_we_q  <= wr_any;
            tbl_re_q  <= rd_any;
            if (wr_any) begin
                rr_ptr_q  <= arb_idx;
                tbl_din_q <= wr_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign occupancy        = occ_q;
    assign tbl_write_enable = tbl_we_q;
    assign tbl_read_enable  = tbl_re_q;
    assign tbl_data_in      = tbl_din_q;
    assign rd_valid         = rd_pipe_q[RD_PIPE-1];
    // Table output is only meaningful for commit reads; drained data never reaches rd_data.
    assign rd_data          = rd_valid ? tbl_data_out : '0;

endmodule

// File: tb/tb_rename_table_scheduler.sv
// Scoreboard bench for rename_table_scheduler with a behavioural FIFO table attached.
module tb_rename_table_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  wr_req;
    logic [15:0] wr_data;
    logic [1:0]  wr_gnt;
    logic        rd_req, rd_gnt, rd_valid;
    logic [7:0]  rd_data;
    logic        flush, flush_busy, flush_done;
    logic [2:0]  occupancy;
    logic        tbl_write_enable, tbl_read_enable;
    logic [7:0]  tbl_data_in, tbl_data_out;

    int n_chk  = 0;
    int n_pass = 0;

    rename_table_scheduler #(.DATA_WIDTH(8), .TABLE_DEPTH(4), .NUM_WR(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wr_req           (wr_req),
        .wr_data          (wr_data),
        .wr_gnt           (wr_gnt),
        .rd_req           (rd_req),
        .rd_gnt           (rd_gnt),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .flush            (flush),
        .flush_busy       (flush_busy),
        .flush_done       (flush_done),
        .occupancy        (occupancy),
        .tbl_write_enable (tbl_write_enable),
        .tbl_read_enable  (tbl_read_enable),
        .tbl_data_in      (tbl_data_in),
        .tbl_data_out     (tbl_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        else             n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural record table: registered read, one cycle latency.
    logic [7:0] tbl_mem[$];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_mem.delete();
            tbl_data_out <= 8'h00;
        end else begin
            if (tbl_read_enable && tbl_mem.size() > 0) tbl_data_out <= tbl_mem.pop_front();
            if (tbl_write_enable) tbl_mem.push_back(tbl_data_in);
        end
    end

    // Reference model of the IDLE-mode grant behaviour plus read scoreboard.
    logic       chk_en = 1'b0;
    int         m_occ  = 0;
    int         m_ptr  = 1;
    logic [7:0] m_recs[$];
    logic [7:0] rq[$];
    logic [1:0] vpipe = 2'b00;
    logic       prev_we = 1'b0, prev_re = 1'b0, prev_chk = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always @(negedge clk) begin
        logic [1:0] exp_gnt;
        logic       exp_rd, nv, nwe, nre;
        int         jj, j;
        if (!reset_n) begin
            m_occ = 0; m_ptr = 1; m_recs.delete(); rq.delete();
            vpipe = 2'b00; prev_we = 1'b0; prev_re = 1'b0; prev_chk = 1'b0;
        end else begin
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, vpipe[1]});
            if (rd_valid && rq.size() > 0) chk("rd_data", {24'd0, rd_data}, {24'd0, rq.pop_front()});
            chk("tbl_we", {31'd0, tbl_write_enable}, {31'd0, prev_we});
            if (prev_we) chk("tbl_data_in", {24'd0, tbl_data_in}, {24'd0, prev_d});
            if (prev_chk) chk("tbl_re", {31'd0, tbl_read_enable}, {31'd0, prev_re});
            nv = 1'b0; nwe = 1'b0; nre = 1'b0;
            if (chk_en) begin
                chk("occupancy", {29'd0, occupancy}, m_occ);
                exp_gnt = 2'b00; jj = 0;
                if (m_occ < 4) begin
                    for (int i = 1; i <= 2; i++) begin
                        j = (m_ptr + i) % 2;
                        if (exp_gnt == 2'b00 && wr_req[j]) begin
                            exp_gnt[j] = 1'b1;
                            jj = j;
                        end
                    end
                end
                exp_rd = rd_req && (m_occ > 0);
                chk("wr_gnt", {30'd0, wr_gnt}, {30'd0, exp_gnt});
                chk("rd_gnt", {31'd0, rd_gnt}, {31'd0, exp_rd});
                if (exp_rd) begin
                    rq.push_back(m_recs.pop_front());
                    m_occ--;
                    nv = 1'b1; nre = 1'b1;
                end
                if (exp_gnt != 2'b00) begin
                    prev_d = wr_data[jj*8 +: 8];
                    m_recs.push_back(prev_d);
                    m_ptr = jj;
                    m_occ++;
                    nwe = 1'b1;
                end
            end
            vpipe    = {vpipe[0], nv};
            prev_we  = nwe;
            prev_re  = nre;
            prev_chk = chk_en;
        end
    end

    initial begin
        logic [8:0] exp_busy, exp_done, exp_re;
        exp_busy = 9'b001111110;
        exp_done = 9'b001000000;
        exp_re   = 9'b000011100;

        // Reset with requests and flush asserted: everything stays quiet.
        reset_n = 1'b0; wr_req = 2'b11; flush = 1'b1; rd_req = 1'b1;
        wr_data = {8'hB1, 8'hA0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_gnt", {30'd0, wr_gnt}, 0);
        chk("rst_rd_gnt", {31'd0, rd_gnt}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_rd_data", {24'd0, rd_data}, 0);
        chk("rst_flush_busy", {31'd0, flush_busy}, 0);
        chk("rst_flush_done", {31'd0, flush_done}, 0);
        chk("rst_occupancy", {29'd0, occupancy}, 0);
        chk("rst_tbl_we", {31'd0, tbl_write_enable}, 0);
        chk("rst_tbl_re", {31'd0, tbl_read_enable}, 0);
        chk("rst_tbl_din", {24'd0, tbl_data_in}, 0);
        @(posedge clk); #1;
        flush = 1'b0; rd_req = 1'b0; wr_req = 2'b00; reset_n = 1'b1; chk_en = 1'b1;
        step(1);

        // Round-robin fill until full, then requests stay pending.
        wr_req = 2'b11;
        @(negedge clk);
        chk("first_gnt_req0", {30'd0, wr_gnt}, 2'b01);
        step(7);
        @(negedge clk);
        chk("full_occupancy", {29'd0, occupancy}, 4);
        wr_req = 2'b00; rd_req = 1'b1;
        step(6);

        // Single write then held read; reads denied when empty.
        rd_req = 1'b0; wr_data = {8'hB1, 8'h11}; wr_req = 2'b01;
        step(1);
        wr_req = 2'b00; rd_req = 1'b1;
        step(5);
        rd_req = 1'b0;

        // Simultaneous read and write at occupancy 2.
        wr_data = {8'h22, 8'h33}; wr_req = 2'b11;
        step(2);
        wr_req = 2'b01; rd_req = 1'b1;
        step(1);
        wr_req = 2'b00; rd_req = 1'b0;
        @(negedge clk);
        chk("both_tbl_en", {30'd0, tbl_write_enable, tbl_read_enable}, 2'b11);
        chk("occ_unchanged", {29'd0, occupancy}, 2);
        wr_req = 2'b10;
        step(1);
        wr_req = 2'b00;
        step(4);

        // Flush with three records while requests are held high.
        chk_en = 1'b0; flush = 1'b1; wr_req = 2'b11; rd_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("flush_busy_c%0d", k), {31'd0, flush_busy}, {31'd0, exp_busy[k]});
            chk($sformatf("flush_done_c%0d", k), {31'd0, flush_done}, {31'd0, exp_done[k]});
            chk($sformatf("drain_re_c%0d", k), {31'd0, tbl_read_enable}, {31'd0, exp_re[k]});
            if (k < 7) begin
                chk($sformatf("drain_wr_gnt_c%0d", k), {30'd0, wr_gnt}, 0);
                chk($sformatf("drain_rd_gnt_c%0d", k), {31'd0, rd_gnt}, 0);
            end
            if (k == 6) chk("flush_occ_zero", {29'd0, occupancy}, 0);
            step(1);
            if (k == 0) flush = 1'b0;
            if (k == 6) begin wr_req = 2'b00; rd_req = 1'b0; end
        end
        m_recs.delete(); m_occ = 0; chk_en = 1'b1;
        step(2);

        // Reset in the middle of a drain.
        wr_data = {8'h44, 8'h55}; wr_req = 2'b11;
        step(2);
        wr_req = 2'b00;
        step(4);
        chk_en = 1'b0; flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        chk("drain_started", {31'd0, flush_busy}, 1);
        step(1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, flush_busy}, 0);
        chk("mid_rst_occ", {29'd0, occupancy}, 0);
        chk("mid_rst_tbl_re", {31'd0, tbl_read_enable}, 0);
        chk("mid_rst_rd_valid", {31'd0, rd_valid}, 0);
        step(2);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("no_done_c%0d", k), {31'd0, flush_done}, 0);
            chk($sformatf("no_busy_c%0d", k), {31'd0, flush_busy}, 0);
            step(1);
        end

        // Normal operation resumes with requester 0 first.
        chk_en = 1'b1; wr_data = {8'h66, 8'h77}; wr_req = 2'b11;
        step(3);
        wr_req = 2'b00; rd_req = 1'b1;
        step(6);
        rd_req = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
